// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: three readers share one ROM. The display fetch
// (requester 0) has absolute priority. Sprite engines 1 and 2 alternate
// round-robin when both ask. A tag pipeline follows each read through the
// ROM latency, so every response comes back marked with its requester.
module sprite_rom_arbiter #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 2,
  parameter int ROM_LAT = 1   // legal range 1..3
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [2:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  output logic [2:0]        gnt,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  output logic [2:0]        rsp_valid,
  output logic [DATA_W-1:0] rsp_data
);

  // Which sprite engine wins when both sprite engines request in the same cycle.
  typedef enum logic {
    PREFER_1 = 1'b0,
    PREFER_2 = 1'b1
  } pref_e;

  pref_e             pref;
  logic [2:0]        accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [2:0]        tag_pipe [ROM_LAT];

  // Combinational one-hot grant: display first, then round-robin between 1 and 2.
  always_comb begin
    // NOTE: every branch starts from this default, so no path can leave gnt unassigned and infer a latch.
    gnt = 3'b000;
    if (!reset_n) begin
      gnt = 3'b000;
    end else if (req[0]) begin
      gnt = 3'b001;
    end else if (req[1] && req[2]) begin
      gnt = (pref == PREFER_1) ? 3'b010 : 3'b100;
    end else if (req[1]) begin
      gnt = 3'b010;
    end else if (req[2]) begin
      gnt = 3'b100;
    end
  end

  assign accept = req & gnt;

  // Select the address of the requester that holds the grant.
  always_comb begin
    sel_addr = addr0;
    if (accept[1]) begin
      sel_addr = addr1;
    end else if (accept[2]) begin
      sel_addr = addr2;
    end
  end

  // Round-robin pointer: it moves only when sprite engine 1 or 2 is served.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: state uses non-blocking assignments, so every flop samples values from before the clock edge.
      pref <= PREFER_1;
    end else if (accept[1]) begin
      pref <= PREFER_2;
    end else if (accept[2]) begin
      pref <= PREFER_1;
    end
  end

  // Register the granted address toward the ROM. Hold it when idle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
    end else if (|accept) begin
      rom_address <= sel_addr;
    end
  end

  // Tag pipeline: carries the one-hot grant in step with the ROM latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this array is a few flops, not a RAM, so it is reset. Reset discards all in-flight reads.
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_pipe[i] <= 3'b000;
      end
    end else begin
      tag_pipe[0] <= accept;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Capture ROM data when a tagged read reaches the end of the pipeline. Otherwise hold it.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 3'b000;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= tag_pipe[ROM_LAT-1];
      if (|tag_pipe[ROM_LAT-1]) begin
        rsp_data <= rom_q;
      end
    end
  end

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: sprite ROM address width.
REQ-002 Parameter DATA_W, default 2: ROM word (palette index) width.
REQ-003 Parameter ROM_LAT, default 1, legal range 1..3: cycles from rom_address update to valid rom_q.
REQ-004 vga_clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 req  in  3  per-requester read request; bit0 = display pixel fetch, bit1/bit2 = sprite engines.
REQ-007 addr0, addr1, addr2  in  ADDR_W each  read address of requester 0/1/2, held stable while its req is high and not granted.
REQ-008 gnt  out  3  one-hot combinational grant; a read is accepted in any cycle where req[i] and gnt[i] are both high.
REQ-009 rom_address  out  ADDR_W  registered address driven to the shared ROM.
REQ-010 rom_q  in  DATA_W  ROM read data.
REQ-011 rsp_valid  out  3  registered one-hot: response for requester i is present this cycle.
REQ-012 rsp_data  out  DATA_W  registered response data, qualified by rsp_valid.

Function
REQ-013 At most one gnt bit shall be high per cycle; gnt shall be 0 when req is 0 and while reset_n is low.
REQ-014 req[0] shall have absolute priority: req[0] high -> gnt = 3'b001 regardless of req[2:1].
REQ-015 With req[0] low, req[1] and req[2] shall be arbitrated round-robin by a 1-bit preference pointer (prefer 1 or prefer 2).
REQ-016 Only one of req[2:1] high -> that requester is granted, independent of the pointer.
REQ-017 Both req[2:1] high -> the preferred requester is granted.
REQ-018 The pointer shall update only on an accepted grant to requester 1 or 2: grant to 1 -> prefer 2; grant to 2 -> prefer 1; grants to requester 0 or idle cycles leave it unchanged.
REQ-019 On an accepted grant in cycle t, rom_address shall take the granted addrN value at the end-of-cycle-t edge; with no grant, rom_address shall hold its value.
REQ-020 A ROM_LAT-deep tag pipeline shall carry the one-hot grant alongside each read; rom_q shall be sampled into rsp_data at the edge ROM_LAT cycles after the rom_address update.
REQ-021 Total latency: grant in cycle t -> rsp_valid[i] high in cycle t+ROM_LAT+1 for exactly one cycle (t+2 at default).
REQ-022 One read shall be accepted per cycle with no bubbles; back-to-back grants yield back-to-back responses, order preserved.
REQ-023 rsp_valid shall be 0 in cycles with no matching in-flight read; rsp_data shall hold its last value when rsp_valid is 0.
REQ-024 Requester 1/2 may be starved indefinitely while req[0] is held high; this is intended (display fetch must never stall).
REQ-025 Dropping req[i] before grant shall withdraw the request with no side effect.

Reset
REQ-026 While reset_n is low: rom_address = 0, rsp_valid = 0, rsp_data = 0, tag pipeline cleared, pointer = prefer 1, gnt = 0.
REQ-027 Assertion of reset_n mid-operation shall discard all in-flight reads; no rsp_valid shall appear for them after release.
REQ-028 First grant shall be possible in the first cycle after reset_n deasserts.

Verification
REQ-029 req=3'b111, addr0=0x0010, hold 4 cycles, ROM_LAT=1 -> gnt=3'b001 every cycle; rom_address=0x0010; rsp_valid=3'b001 from cycle 2 for 4 cycles, rsp_data = ROM[0x0010].
REQ-030 After reset, req=3'b110 held 4 cycles, addr1=0x0100, addr2=0x0200 -> gnt sequence 010,100,010,100; rsp_valid same sequence delayed 2 cycles, data ROM[0x0100]/ROM[0x0200] alternating.
REQ-031 req=3'b100 only, 3 cycles -> gnt=3'b100 each cycle; pointer ends at prefer 1; next req=3'b110 grants requester 1 first.
REQ-032 Grant to requester 2 at cycle t, reset_n low in cycle t+1, released cycle t+2 -> rsp_valid stays 0 through t+4; rom_address=0.
REQ-033 ROM_LAT=3, single grant to requester 1 at cycle 5 -> rsp_valid=3'b010 only in cycle 9, rsp_data = ROM[addr1].
REQ-034 req=3'b000 for 10 cycles after a response -> gnt=0, rsp_valid=0, rom_address and rsp_data unchanged.
